// File: rtl/tea_io_pkg.sv
// Shared constants and state encoding for the TEA io mailbox.
package tea_io_pkg;

    localparam logic [4:0] ADDR_DATA_BASE = 5'h00;
    localparam logic [4:0] DATA_COUNT     = 5'd8;
    localparam logic [4:0] ADDR_CNT_LO    = 5'h1C;
    localparam logic [4:0] ADDR_CNT_HI    = 5'h1D;
    localparam logic [4:0] ADDR_DEBUG     = 5'h1E;
    localparam logic [4:0] ADDR_STATUS    = 5'h1F;

    // Status read bits (bit0 is an active-low job request) and status write bits
    localparam int unsigned ST_NREQ_BIT = 0;
    localparam int unsigned ST_RES_BIT  = 1;
    localparam int unsigned ST_ERR_BIT  = 2;
    localparam int unsigned ST_DONE_BIT = 0;
    localparam int unsigned ST_CLR_BIT  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RES  = 2'd2
    } state_t;

endpackage

// File: rtl/tea_io_mailbox.sv
// IO-bus mailbox feeding 64-bit TEA jobs to the CPU and returning results to the host.
// Latency: accept/done/take each take effect on the next edge; host_ready and res_valid are state decodes only.
module tea_io_mailbox
    import tea_io_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter logic [4:0]  STATUS_ADDR = ADDR_STATUS,
    parameter logic [4:0]  DEBUG_ADDR  = ADDR_DEBUG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  io_addr,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [7:0]  io_wrdata,
    output logic [7:0]  io_rddata,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [63:0] host_din,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_dout,
    output logic        dbg_valid,
    output logic [7:0]  dbg_data
);

    state_t                 state;
    logic [63:0]            in_reg;
    logic [63:0]            out_reg;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   err;

    logic [4:0]             data_idx;
    logic                   is_data;
    logic                   status_wr;
    logic [15:0]            cnt_ext;
    logic [7:0]             status;
    logic                   io_rd_unused;

    // Reads have no side effects, so the read strobe is not needed
    assign io_rd_unused = io_rd;

    assign data_idx   = io_addr - ADDR_DATA_BASE;
    assign is_data    = (data_idx < DATA_COUNT);
    assign status_wr  = io_wr && (io_addr == STATUS_ADDR);
    assign host_ready = (state == IDLE);
    assign res_valid  = (state == RES);

    always_comb begin
        cnt_ext = '0;
        cnt_ext[CNT_WIDTH-1:0] = cnt;

        status = '0;
        status[ST_NREQ_BIT] = (state != PEND);
        status[ST_RES_BIT]  = (state == RES);
        status[ST_ERR_BIT]  = err;

        io_rddata = '0;
        if (is_data)
            io_rddata = in_reg[{data_idx[2:0], 3'b000} +: 8];
        else if (io_addr == ADDR_CNT_LO)
            io_rddata = cnt_ext[7:0];
        else if (io_addr == ADDR_CNT_HI)
            io_rddata = cnt_ext[15:8];
        else if (io_addr == STATUS_ADDR)
            io_rddata = status;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_reg    <= '0;
            out_reg   <= '0;
            res_dout  <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            dbg_valid <= 1'b0;
            dbg_data  <= '0;
        end else begin
            dbg_valid <= 1'b0;

            if (io_wr && is_data)
                out_reg[{data_idx[2:0], 3'b000} +: 8] <= io_wrdata;

            if (io_wr && (io_addr == DEBUG_ADDR)) begin
                dbg_valid <= 1'b1;
                dbg_data  <= io_wrdata;
            end

            // Clear wins over a stray done written outside a pending job
            if (status_wr) begin
                if (io_wrdata[ST_CLR_BIT])
                    err <= 1'b0;
                else if (io_wrdata[ST_DONE_BIT] && (state != PEND))
                    err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (host_valid) begin
                        in_reg <= host_din;
                        cnt    <= '0;
                        state  <= PEND;
                    end
                end
                PEND: begin
                    if (cnt != '1)
                        cnt <= cnt + 1'b1;
                    if (status_wr && io_wrdata[ST_DONE_BIT]) begin
                        res_dout <= out_reg;
                        state    <= RES;
                    end
                end
                RES: begin
                    if (res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_io_mailbox.sv
// Randomized directed bench for tea_io_mailbox against a job-level reference model.
module tb_tea_io_mailbox;

    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;
    localparam int PH_IDLE = 0;
    localparam int PH_PEND = 1;
    localparam int PH_RES  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  io_addr;
    logic        io_rd;
    logic        io_wr;
    logic [7:0]  io_wrdata;
    logic [7:0]  io_rddata;
    logic        host_valid;
    logic        host_ready;
    logic [63:0] host_din;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_dout;
    logic        dbg_valid;
    logic [7:0]  dbg_data;

    tea_io_mailbox #(.CNT_WIDTH(CW), .STATUS_ADDR(5'h1F), .DEBUG_ADDR(5'h1E)) dut (
        .clk(clk), .rst(rst),
        .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
        .io_wrdata(io_wrdata), .io_rddata(io_rddata),
        .host_valid(host_valid), .host_ready(host_ready), .host_din(host_din),
        .res_valid(res_valid), .res_ready(res_ready), .res_dout(res_dout),
        .dbg_valid(dbg_valid), .dbg_data(dbg_data)
    );

    always #50 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: job phase plus the values each register should hold
    int          phase;
    logic [63:0] m_in, m_out, m_res;
    logic        m_err;
    logic [7:0]  m_dbg;
    logic        dbg_exp;
    int unsigned acc_cyc;
    int unsigned m_hold;

    function automatic int unsigned sat(input int unsigned x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dbg_exp = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        io_rd   = 1'b1;
        io_addr = a;
        #1;
        d = io_rddata;
        io_rd = 1'b0;
    endtask

    task automatic model_reset();
        phase = PH_IDLE; m_in = '0; m_out = '0; m_res = '0;
        m_err = 1'b0; m_dbg = '0; dbg_exp = 1'b0; m_hold = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        int ph;
        ph = phase;
        io_addr = a; io_wrdata = d; io_wr = 1'b1;
        tick();
        io_wr = 1'b0;
        if (a < 5'd8) m_out[int'(a) * 8 +: 8] = d;
        if (a == 5'h1F) begin
            if (d[7]) m_err = 1'b0;
            else if (d[0] && ph != PH_PEND) m_err = 1'b1;
            if (d[0] && ph == PH_PEND) begin
                phase  = PH_RES;
                m_res  = m_out;
                m_hold = sat(cyc - acc_cyc);
            end
        end
        if (a == 5'h1E) begin
            m_dbg = d;
            dbg_exp = 1'b1;
        end
    endtask

    task automatic accept(input logic [63:0] din);
        host_din = din; host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        phase = PH_PEND; m_in = din; acc_cyc = cyc;
    endtask

    task automatic take();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        phase = PH_IDLE;
    endtask

    task automatic check_all(input string tag);
        logic [7:0]  b, lo, hi;
        logic [63:0] inr;
        int unsigned ecnt;
        ecnt = (phase == PH_PEND) ? sat(cyc - acc_cyc) : m_hold;
        check({tag, "/host_ready"}, 64'(host_ready), 64'(phase == PH_IDLE));
        check({tag, "/res_valid"},  64'(res_valid),  64'(phase == PH_RES));
        check({tag, "/res_dout"},   res_dout, m_res);
        check({tag, "/dbg_valid"},  64'(dbg_valid), 64'(dbg_exp));
        check({tag, "/dbg_data"},   64'(dbg_data), 64'(m_dbg));
        rd(5'h1F, b);
        check({tag, "/status"}, 64'(b),
              64'({5'b0, m_err, phase == PH_RES, phase != PH_PEND}));
        rd(5'h1C, lo);
        rd(5'h1D, hi);
        check({tag, "/counter"}, 64'({hi, lo}), 64'(ecnt));
        for (int k = 0; k < 8; k++) begin
            rd(5'(k), b);
            inr[k * 8 +: 8] = b;
        end
        check({tag, "/in_reg"}, inr, m_in);
    endtask

    initial begin
        logic [7:0]  b;
        logic [63:0] held;
        rst = 1'b1; io_addr = '0; io_rd = 1'b0; io_wr = 1'b0; io_wrdata = '0;
        host_valid = 1'b0; host_din = '0; res_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        check_all("reset");

        // First job with fixed plaintext and result bytes
        accept(64'h4433_2211_7856_3412);
        rd(5'h00, b); check("byte0", 64'(b), 64'h12);
        rd(5'h03, b); check("byte3", 64'(b), 64'h78);
        rd(5'h07, b); check("byte7", 64'(b), 64'h44);
        check_all("accept1");
        for (int k = 0; k < 8; k++) wr(5'(k), 8'hA0 + 8'(k));
        repeat (92) tick();
        wr(5'h1F, 8'h01);
        check("res_fixed", res_dout, 64'hA7A6_A5A4_A3A2_A1A0);
        check_all("done1");

        // Result held off while the host also offers a new job
        held = res_dout;
        host_din = 64'hDEAD_BEEF_0BAD_F00D; host_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("res_stable", res_dout, held);
            check("rv_hold", 64'(res_valid), 64'h1);
        end
        take();
        check_all("take1");
        host_valid = 1'b0;

        // Sticky error set outside PEND, then cleared; clear beats set
        wr(5'h1F, 8'h01);
        check_all("err_set");
        wr(5'h1F, 8'h80);
        check_all("err_clr");
        wr(5'h1F, 8'h01);
        wr(5'h1F, 8'h81);
        check_all("err_prio");

        // Debug port pulse
        wr(5'h1E, 8'h8C);
        check_all("dbg_pulse");
        tick();
        check_all("dbg_after");

        // Randomized jobs
        for (int j = 0; j < 4; j++) begin
            accept({$urandom, $urandom});
            check_all("rj_accept");
            for (int k = 0; k < 10; k++) wr(5'($urandom_range(0, 7)), 8'($urandom));
            wr(5'h10, 8'($urandom));
            repeat ($urandom_range(1, 40)) tick();
            check_all("rj_pend");
            wr(5'h1F, {1'b0, 6'($urandom), 1'b1});
            check_all("rj_done");
            wr(5'($urandom_range(0, 7)), 8'($urandom));
            repeat ($urandom_range(0, 4)) tick();
            check_all("rj_res");
            take();
            check_all("rj_take");
        end

        // Counter saturation
        accept({$urandom, $urandom});
        repeat (CMAX + 10) tick();
        check_all("sat_pend");
        wr(5'h1F, 8'h01);
        tick();
        check_all("sat_res");
        take();

        // Reset in the middle of a pending job
        wr(5'h1F, 8'h01);
        wr(5'h1E, 8'($urandom));
        accept({$urandom, $urandom});
        wr(5'h02, 8'h5A);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        model_reset();
        check_all("rst_mid");
        rst = 1'b0;
        tick();
        accept({$urandom, $urandom});
        wr(5'h1F, 8'h01);
        check_all("post_rst_job");
        take();
        check_all("post_rst_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
